// File: rtl/add4_nibble_sched_if.sv
// rtl/add4_nibble_sched_if.sv - requester, response and shared adder slice signals of add4_nibble_sched
interface add4_nibble_sched_if #(
  parameter int NREQ = 4,
  parameter int NNIB = 4
);
  localparam int W   = 4 * NNIB;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              rsp_err;
  logic [3:0]        add_a;
  logic [3:0]        add_b;
  logic [4:0]        add_s;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_s,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, add_a, add_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_s,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, add_a, add_b
  );
endinterface

// File: rtl/add4_nibble_sched.sv
// rtl/add4_nibble_sched.sv - round-robin nibble-serial adder scheduler over one shared 4-bit slice
// Optional ADD_RECHECK_EN: every slice pass is sampled twice and mismatches are flagged on rsp_err.
module add4_nibble_sched #(
  parameter int NREQ = 4,
  parameter int NNIB = 4
) (
  input  logic clk,
  input  logic rst_n,
  add4_nibble_sched_if.slave bus
);
  localparam int W   = 4 * NNIB;
  localparam int IDW = $clog2(NREQ);
  localparam int NBW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, INC, RESP} state_t;

  state_t                 state;
  logic [IDW-1:0]         last_grant;
  logic [IDW-1:0]         gid;
  logic [NNIB-1:0][3:0]   op_a;
  logic [NNIB-1:0][3:0]   op_b;
  logic [NNIB-1:0][3:0]   result;
  logic [NBW-1:0]         nib;
  logic                   carry;
  logic                   s_c;
  logic [NREQ-1:0]        req_ready_q;
  logic                   rsp_valid_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [W:0]             rsp_sum_q;
  logic [3:0]             add_a_q;
  logic [3:0]             add_b_q;

  logic [NREQ-1:0][W-1:0] ra;
  logic [NREQ-1:0][W-1:0] rb;
  assign ra = bus.req_a;
  assign rb = bus.req_b;

  // Nearest requester after last_grant wins: later (closer) offsets overwrite earlier ones.
  logic           pick_ok;
  logic [IDW-1:0] pick;
  logic [IDW:0]   cand;
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k + 1);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (bus.req_valid[cand[IDW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = cand[IDW-1:0];
      end
    end
  end

  logic pass_go;
`ifdef ADD_RECHECK_EN
  logic       phase;
  logic       err;
  logic       rsp_err_q;
  logic [4:0] chk;
  logic       mism;
  assign pass_go     = phase;
  assign mism        = phase && (bus.add_s != chk);
  assign bus.rsp_err = rsp_err_q;
`else
  assign pass_go     = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  logic [NNIB-1:0][3:0] res_upd;
  logic                 carry_new;
  logic                 adv;
  logic                 last_nib;
  logic [NBW-1:0]       nib_nx;
  always_comb begin
    res_upd      = result;
    res_upd[nib] = bus.add_s[3:0];
    carry_new    = (state == INC) ? (s_c | bus.add_s[4]) : bus.add_s[4];
    adv          = pass_go && ((state == ADD && !carry) || state == INC);
    last_nib     = (nib == NBW'(NNIB - 1));
    nib_nx       = nib + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      gid         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      nib         <= '0;
      carry       <= 1'b0;
      s_c         <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
`ifdef ADD_RECHECK_EN
      phase       <= 1'b0;
      err         <= 1'b0;
      rsp_err_q   <= 1'b0;
      chk         <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      case (state)
        IDLE: if (pick_ok) begin
          gid         <= pick;
          op_a        <= ra[pick];
          op_b        <= rb[pick];
          add_a_q     <= ra[pick][3:0];
          add_b_q     <= rb[pick][3:0];
          req_ready_q <= NREQ'(1) << pick;
          nib         <= '0;
          carry       <= 1'b0;
          state       <= ADD;
`ifdef ADD_RECHECK_EN
          err         <= 1'b0;
          rsp_err_q   <= 1'b0;
`endif
        end
        ADD: if (pass_go && carry) begin
          // Incoming carry: resolve it with an increment pass on the same slice.
          s_c     <= bus.add_s[4];
          add_a_q <= bus.add_s[3:0];
          add_b_q <= 4'd1;
          state   <= INC;
        end
        INC: ;
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          last_grant  <= gid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (adv) begin
        result <= res_upd;
        carry  <= carry_new;
        if (last_nib) begin
          rsp_sum_q   <= {carry_new, res_upd};
          rsp_id_q    <= gid;
          rsp_valid_q <= 1'b1;
          add_a_q     <= '0;
          add_b_q     <= '0;
          state       <= RESP;
`ifdef ADD_RECHECK_EN
          rsp_err_q   <= err | mism;
`endif
        end else begin
          nib     <= nib_nx;
          add_a_q <= op_a[nib_nx];
          add_b_q <= op_b[nib_nx];
          state   <= ADD;
        end
      end

`ifdef ADD_RECHECK_EN
      if (state == ADD || state == INC) begin
        phase <= !phase;
        if (!phase)
          chk <= bus.add_s;
        if (mism)
          err <= 1'b1;
      end
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
endmodule

// File: tb/tb_add4_nibble_sched.sv
// tb/tb_add4_nibble_sched.sv - directed vector bench for add4_nibble_sched (NREQ=4, NNIB=4)
module tb_add4_nibble_sched;
  logic clk;
  logic rst_n;
  logic corrupt;
  int   errors;
  int   checks;

`ifdef ADD_RECHECK_EN
  localparam int MUL = 2;
`else
  localparam int MUL = 1;
`endif

  add4_nibble_sched_if #(.NREQ(4), .NNIB(4)) bus ();

  add4_nibble_sched #(.NREQ(4), .NNIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0][15:0] ta;
  logic [3:0][15:0] tbv;
  assign bus.req_a = ta;
  assign bus.req_b = tbv;
  assign bus.add_s = ({1'b0, bus.add_a} + {1'b0, bus.add_b}) ^ {4'b0, corrupt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;
    int          passes;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] id, input string nm);
    int n;
    n = 0;
    while (!bus.req_ready[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready[id]) check(nm, 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) check(nm, 64'd0, 64'd1);
  endtask

  task automatic do_txn(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                        input bit corrupt_first, output logic [16:0] sum, output int rid,
                        output int lat, output logic err);
    int n;
    sum = '0; rid = -1; lat = -1; err = 1'b0;
    ta[id] = a;
    tbv[id] = b;
    bus.req_valid[id] = 1'b1;
    n = 0;
    while (!bus.req_ready[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid[id] = 1'b0;
    if (!bus.req_ready[id]) begin
      check("txn_grant_timeout", 64'd0, 64'd1);
      return;
    end
    lat = 0;
    if (corrupt_first) begin
      corrupt = 1'b1;
      @(negedge clk);
      corrupt = 1'b0;
      lat = 1;
    end
    while (!bus.rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      check("txn_rsp_timeout", 64'd0, 64'd1);
      return;
    end
    sum = bus.rsp_sum;
    rid = int'(bus.rsp_id);
    err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [16:0] sum;
    logic [16:0] cap_sum;
    logic [1:0]  cap_id;
    int          rid;
    int          lat;
    int          viol;
    logic        err;
    logic [15:0] rra [4];
    logic [15:0] rrb [4];

    errors = 0;
    checks = 0;
    corrupt = 1'b0;
    ta = '0;
    tbv = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    rst_n = 1'b0;

    vt[0] = '{16'h00FF, 16'h0001, 17'h00100, 6};
    vt[1] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 7};
    vt[2] = '{16'h1234, 16'h4321, 17'h05555, 4};
    vt[3] = '{16'h0000, 16'h0000, 17'h00000, 4};
    vt[4] = '{16'h8000, 16'h8000, 17'h10000, 4};
    vt[5] = '{16'h0FFF, 16'h0001, 17'h01000, 7};
    vt[6] = '{16'hFFFF, 16'h0001, 17'h10000, 7};
    vt[7] = '{16'h0F0F, 16'h0101, 17'h01010, 6};

    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_add_ab", 64'({bus.add_a, bus.add_b}), 64'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(2'd0, vt[i].a, vt[i].b, 1'b0, sum, rid, lat, err);
      check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vt[i].sum));
      check($sformatf("vec%0d_id", i), 64'(rid), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].passes * MUL));
      check($sformatf("vec%0d_err", i), 64'(err), 64'd0);
      check($sformatf("vec%0d_idle", i), 64'({bus.rsp_valid, bus.add_a, bus.add_b}), 64'd0);
    end

    // Back-pressure: result held, no new grant while requester 1 waits.
    ta[0] = 16'h1234; tbv[0] = 16'h1111;
    bus.req_valid[0] = 1'b1;
    wait_grant(2'd0, "bp_grant_timeout");
    bus.req_valid[0] = 1'b0;
    ta[1] = 16'h0001; tbv[1] = 16'h0002;
    bus.req_valid[1] = 1'b1;
    wait_rsp("bp_rsp_timeout");
    cap_sum = bus.rsp_sum;
    cap_id = bus.rsp_id;
    check("bp_sum", 64'(cap_sum), 64'h2345);
    check("bp_id", 64'(cap_id), 64'd0);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_sum !== cap_sum || bus.rsp_id !== cap_id || bus.req_ready !== 4'b0)
        viol++;
    end
    check("bp_hold_violations", 64'(viol), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_release_idle", 64'({bus.rsp_valid, bus.req_ready}), 64'd0);
    @(negedge clk);
    check("bp_next_grant", 64'(bus.req_ready), 64'b0010);
    bus.req_valid[1] = 1'b0;
    wait_rsp("bp2_rsp_timeout");
    check("bp2_sum_id", 64'({bus.rsp_id, bus.rsp_sum}), 64'({2'd1, 17'h00003}));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Asynchronous reset during nibble 2 of requester 2; requester 0 must win afterwards.
    ta[2] = 16'h1111; tbv[2] = 16'h2222;
    bus.req_valid[2] = 1'b1;
    wait_grant(2'd2, "rst_grant_timeout");
    @(negedge clk);
    @(negedge clk);
    check("mid_add_nib2", 64'({bus.add_a, bus.add_b}), 64'h12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.add_a, bus.add_b}), 64'd0);
    ta[0] = 16'h0003; tbv[0] = 16'h0004;
    bus.req_valid = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(2'd0, "post_rst_grant_timeout");
    check("post_rst_grant", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    wait_rsp("post_rst_rsp_timeout");
    check("post_rst_sum_id", 64'({bus.rsp_id, bus.rsp_sum}), 64'({2'd0, 17'h00007}));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Round robin with all four requesters valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rra = '{16'h1234, 16'hFFFF, 16'h8001, 16'h0F0F};
    rrb = '{16'h0001, 16'h0001, 16'h8FFF, 16'hF0F1};
    for (int i = 0; i < 4; i++) begin
      ta[i] = rra[i];
      tbv[i] = rrb[i];
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("rr%0d_timeout", k));
      check($sformatf("rr%0d_id", k), 64'(bus.rsp_id), 64'(k % 4));
      check($sformatf("rr%0d_sum", k), 64'(bus.rsp_sum),
            64'({1'b0, rra[k % 4]} + {1'b0, rrb[k % 4]}));
      if (k == 4) bus.req_valid = '0;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);

`ifdef ADD_RECHECK_EN
    do_txn(2'd0, 16'h00FF, 16'h0001, 1'b1, sum, rid, lat, err);
    check("recheck_sum", 64'(sum), 64'h00100);
    check("recheck_err", 64'(err), 64'd1);
    check("recheck_latency", 64'(lat), 64'd12);
    do_txn(2'd0, 16'h1234, 16'h4321, 1'b0, sum, rid, lat, err);
    check("recheck_next_sum", 64'(sum), 64'h05555);
    check("recheck_next_err", 64'(err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
